// File: rtl/nexys_starship_ssd_scanner.sv
// Multiplexed N-digit seven-segment scanner with tear-free frame loading, dead time and blink.
// Optional macro SSD_BRIGHTNESS_EN adds a 4-bit brightness input that gates the anode within each slot.
module nexys_starship_ssd_scanner #(
    parameter int NUM_DIGITS  = 8,
    parameter int PRESCALE_W  = 14,
    parameter int DEAD_CYCLES = 4,
    parameter int BLINK_W     = 25,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`ifdef SSD_BRIGHTNESS_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              cathodes,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    pending
);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   en;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blink;
    } frame_t;

    logic [PRESCALE_W-1:0] r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [BLINK_W-1:0]    r_blink_cnt;
    logic                  r_blink_phase;
    frame_t                r_active;
    frame_t                r_pend;
    logic                  r_pending;
    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]            r_cathodes;

    frame_t                w_in_frame;
    logic                  w_presc_tc;
    logic                  w_last_digit;
    logic                  w_boundary;
    logic [3:0]            w_nibble;
    logic                  w_dead;
    logic                  w_bright_ok;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic [7:0]            w_cath_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign w_in_frame   = '{data: digit_data, en: digit_en, dp: dp_in, blink: blink_mask};
    assign w_presc_tc   = &r_presc;
    assign w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_boundary   = w_presc_tc & w_last_digit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_presc     <= r_presc + PRESCALE_W'(1);
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            // Phase flips once per full counter period, i.e. every 2**BLINK_W cycles.
            if (&r_blink_cnt)
                r_blink_phase <= ~r_blink_phase;
            if (w_presc_tc)
                r_idx <= w_last_digit ? '0 : r_idx + IDX_W'(1);
        end
    end

    // NOTE: both frame stores are reset so a fresh power-up shows a fully blanked display.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_active  <= '0;
            r_pend    <= '0;
            r_pending <= 1'b0;
        end else begin
            // Commit uses the old pending content; a same-cycle load waits for the next boundary.
            if (w_boundary && r_pending)
                r_active <= r_pend;
            if (load)
                r_pend <= w_in_frame;
            r_pending <= load | (r_pending & ~w_boundary);
        end
    end

    assign w_nibble = r_active.data[4*int'(r_idx) +: 4];
    assign w_dead   = (r_presc < PRESCALE_W'(DEAD_CYCLES));

`ifdef SSD_BRIGHTNESS_EN
    logic [PRESCALE_W+3:0] w_presc_ext;
    assign w_presc_ext = {r_presc, 4'b0000};
    assign w_bright_ok = (w_presc_ext[PRESCALE_W+3 -: 4] <= brightness);
`else
    assign w_bright_ok = 1'b1;
`endif

    assign w_lit = ~w_dead & w_bright_ok & r_active.en[r_idx]
                 & ~(r_active.blink[r_idx] & r_blink_phase);

    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
    always_comb begin
        w_an_next   = '1;
        w_cath_next = 8'hFF;
        if (w_lit) begin
            w_an_next[r_idx] = 1'b0;
            w_cath_next      = {hex_to_seg(w_nibble), ~r_active.dp[r_idx]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_an       <= '1;
            r_cathodes <= 8'hFF;
        end else begin
            r_an       <= w_an_next;
            r_cathodes <= w_cath_next;
        end
    end

    assign an        = r_an;
    assign cathodes  = r_cathodes;
    assign digit_idx = r_idx;
    assign pending   = r_pending;

endmodule
